// File: rtl/mmem_port_arb.sv
// mmem_port_arb
//
// Shares the CADR M memory (32 x 32, registered read port, write port, one
// shared address) between the microcode datapath (CPU) and the spy/debug
// requester. The CPU always wins. The spy is served in idle CPU cycles. If a
// request waits STARVE_LIMIT busy cycles, the CPU is stalled for one cycle to
// force the grant. A shadow register keeps the CPU's last read data intact
// when a spy read overwrites the memory's output register.
//
// Parameters:
//   STARVE_LIMIT  busy CPU cycles a pending spy request may wait (0 = never force)
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cpu_madr/mrp/mwp/l              CPU address, read pass, write pass, write data
//   cpu_mmem, cpu_stall             CPU read data; CPU op not performed this cycle
//   spy_req/wr/adr/wdata            spy four-phase request and transaction fields
//   spy_ack, spy_rdata              spy completion and read data
//   mem_madr/mrp/mwp/l, mem_mmem    M memory side (mem_mmem has 1-cycle latency)
// Configuration macro:
//   MMEM_ARB_BYPASS_EN  forward cpu_l to cpu_mmem after a CPU op with mrp and mwp both set
module mmem_port_arb #(
    parameter int unsigned STARVE_LIMIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  cpu_madr,
    input  logic        cpu_mrp,
    input  logic        cpu_mwp,
    input  logic [31:0] cpu_l,
    output logic [31:0] cpu_mmem,
    output logic        cpu_stall,
    input  logic        spy_req,
    input  logic        spy_wr,
    input  logic [4:0]  spy_adr,
    input  logic [31:0] spy_wdata,
    output logic        spy_ack,
    output logic [31:0] spy_rdata,
    output logic [4:0]  mem_madr,
    output logic        mem_mrp,
    output logic        mem_mwp,
    output logic [31:0] mem_l,
    input  logic [31:0] mem_mmem
);

    localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StWait, StRdata, StAck} state_e;

    state_e          state_q, state_d;
    logic            spy_wr_q;
    logic [4:0]      spy_adr_q;
    logic [31:0]     spy_wdata_q;
    logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
    logic            spy_ack_q;
    logic [31:0]     spy_rdata_q;
    logic            cpu_rd_q;
    logic [31:0]     cpu_hold_q;
    logic [31:0]     cpu_rdata;

    logic cpu_busy;
    logic forced;
    logic grant;
    logic latch_spy;
    logic capture_rdata;

    assign cpu_busy = cpu_mrp | cpu_mwp;
    assign forced   = (STARVE_LIMIT != 0) && (starve_cnt_q == CntMax);
    // Gated by reset so nothing is granted or stalled in the cycle reset is sampled.
    assign grant    = (state_q == StWait) && !reset && (!cpu_busy || forced);

    // Spy sequencing.
    always_comb begin
        state_d       = state_q;
        starve_cnt_d  = starve_cnt_q;
        latch_spy     = 1'b0;
        capture_rdata = 1'b0;
        case (state_q)
            StIdle: begin
                if (spy_req) begin
                    latch_spy    = 1'b1;
                    starve_cnt_d = '0;
                    state_d      = StWait;
                end
            end
            StWait: begin
                if (grant) begin
                    state_d = spy_wr_q ? StAck : StRdata;
                end else if (starve_cnt_q != CntMax) begin
                    starve_cnt_d = starve_cnt_q + 1'b1;
                end
            end
            StRdata: begin
                capture_rdata = 1'b1;
                state_d       = StAck;
            end
            StAck: begin
                if (!spy_req) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Memory port mux; enables are held off while in reset.
    always_comb begin
        mem_madr = cpu_madr;
        mem_mrp  = cpu_mrp;
        mem_mwp  = cpu_mwp;
        mem_l    = cpu_l;
        if (grant) begin
            mem_madr = spy_adr_q;
            mem_mrp  = !spy_wr_q;
            mem_mwp  = spy_wr_q;
            mem_l    = spy_wdata_q;
        end
        if (reset) begin
            mem_mrp = 1'b0;
            mem_mwp = 1'b0;
        end
    end

    assign cpu_stall = grant && forced && cpu_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            spy_wr_q     <= 1'b0;
            spy_adr_q    <= '0;
            spy_wdata_q  <= '0;
            starve_cnt_q <= '0;
            spy_ack_q    <= 1'b0;
            spy_rdata_q  <= '0;
            cpu_rd_q     <= 1'b0;
            cpu_hold_q   <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            if (latch_spy) begin
                spy_wr_q    <= spy_wr;
                spy_adr_q   <= spy_adr;
                spy_wdata_q <= spy_wdata;
            end
            if (capture_rdata) begin
                spy_rdata_q <= mem_mmem;
            end
            // Ack drops in the same edge that returns the FSM to idle.
            spy_ack_q <= (state_q == StAck) && spy_req;
            cpu_rd_q  <= cpu_mrp && !grant;
            // Shadow the data the CPU is seeing so a later spy read cannot disturb it.
            if (cpu_rd_q) begin
                cpu_hold_q <= cpu_mmem;
            end
        end
    end

`ifdef MMEM_ARB_BYPASS_EN
    logic        byp_q;
    logic [31:0] byp_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp_q      <= cpu_mrp && cpu_mwp && !grant;
            byp_data_q <= cpu_l;
        end
    end

    assign cpu_rdata = byp_q ? byp_data_q : mem_mmem;
`else
    assign cpu_rdata = mem_mmem;
`endif

    assign cpu_mmem  = cpu_rd_q ? cpu_rdata : cpu_hold_q;
    assign spy_ack   = spy_ack_q;
    assign spy_rdata = spy_rdata_q;

endmodule

// File: tb/tb_mmem_port_arb.sv
// Testbench for mmem_port_arb: a forcing instance (STARVE_LIMIT = 4) and a
// non-forcing instance (STARVE_LIMIT = 0) sharing the CPU bus, each with its
// own behavioural M memory. Expected CPU read data and spy read data are
// pushed to queues by the drivers and popped by a separate monitor.
module tb_mmem_port_arb;

    localparam int unsigned Starve = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [4:0]  cpu_madr;
    logic        cpu_mrp, cpu_mwp;
    logic [31:0] cpu_l;
    logic [31:0] cpu_mmem, cpu_mmem0;
    logic        cpu_stall, cpu_stall0;
    logic        spy_req, spy_wr, spy_ack;
    logic [4:0]  spy_adr;
    logic [31:0] spy_wdata, spy_rdata;
    logic        spy_req0, spy_wr0, spy_ack0;
    logic [4:0]  spy_adr0;
    logic [31:0] spy_wdata0, spy_rdata0;
    logic [4:0]  mem_madr, mem_madr0;
    logic        mem_mrp, mem_mwp, mem_mrp0, mem_mwp0;
    logic [31:0] mem_l, mem_l0, mem_mmem, mem_mmem0;

    mmem_port_arb #(.STARVE_LIMIT(Starve)) u_dut (
        .clk(clk), .reset(reset),
        .cpu_madr(cpu_madr), .cpu_mrp(cpu_mrp), .cpu_mwp(cpu_mwp), .cpu_l(cpu_l),
        .cpu_mmem(cpu_mmem), .cpu_stall(cpu_stall),
        .spy_req(spy_req), .spy_wr(spy_wr), .spy_adr(spy_adr), .spy_wdata(spy_wdata),
        .spy_ack(spy_ack), .spy_rdata(spy_rdata),
        .mem_madr(mem_madr), .mem_mrp(mem_mrp), .mem_mwp(mem_mwp), .mem_l(mem_l),
        .mem_mmem(mem_mmem)
    );

    mmem_port_arb #(.STARVE_LIMIT(0)) u_dut_nf (
        .clk(clk), .reset(reset),
        .cpu_madr(cpu_madr), .cpu_mrp(cpu_mrp), .cpu_mwp(cpu_mwp), .cpu_l(cpu_l),
        .cpu_mmem(cpu_mmem0), .cpu_stall(cpu_stall0),
        .spy_req(spy_req0), .spy_wr(spy_wr0), .spy_adr(spy_adr0), .spy_wdata(spy_wdata0),
        .spy_ack(spy_ack0), .spy_rdata(spy_rdata0),
        .mem_madr(mem_madr0), .mem_mrp(mem_mrp0), .mem_mwp(mem_mwp0), .mem_l(mem_l0),
        .mem_mmem(mem_mmem0)
    );

    // Behavioural M memories: registered read, read-before-write.
    logic        ram_clr;
    logic [31:0] ram [32];
    logic [31:0] ram0 [32];
    always_ff @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 32; i++) begin
                ram[i]  <= '0;
                ram0[i] <= '0;
            end
            mem_mmem  <= '0;
            mem_mmem0 <= '0;
        end else begin
            if (mem_mwp) ram[mem_madr] <= mem_l;
            if (mem_mrp) mem_mmem <= ram[mem_madr];
            if (mem_mwp0) ram0[mem_madr0] <= mem_l0;
            if (mem_mrp0) mem_mmem0 <= ram0[mem_madr0];
        end
    end

    // Reference model: architectural memory contents and the CPU's last read.
    logic [31:0] exp_mem [32];
    logic [31:0] last_rd;
    logic [31:0] cpu_q [$];
    logic [32:0] spy_q [$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc, stall_cnt, stall_at;
    logic        g0, s0;
    logic        ack_prev = 1'b0;
    logic        cpu_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // One CPU cycle; entered and left at posedge+1.
    task automatic cpu_step(input logic mrp, input logic mwp, input logic [4:0] adr,
                            input logic [31:0] l, output logic st);
        cpu_mrp = mrp; cpu_mwp = mwp; cpu_madr = adr; cpu_l = l;
        @(negedge clk);
        st = cpu_stall;
        g0 = mem_mrp0 && (mem_madr0 == 5'd2);
        s0 = cpu_stall0;
        if (st) begin
            stall_cnt++;
            stall_at = cyc;
            chk("stall_needs_spy", {31'b0, spy_req}, 32'd1);
        end else begin
            if (mrp) begin
`ifdef MMEM_ARB_BYPASS_EN
                last_rd = mwp ? l : exp_mem[adr];
`else
                last_rd = exp_mem[adr];
`endif
            end
            if (mwp) exp_mem[adr] = l;
        end
        cpu_q.push_back(last_rd);
        cyc++;
        @(posedge clk); #1;
    endtask

    // CPU op held until performed.
    task automatic cpu_op(input logic mrp, input logic mwp, input logic [4:0] adr,
                          input logic [31:0] l);
        logic st;
        int   tries;
        tries = 0;
        cpu_step(mrp, mwp, adr, l, st);
        while (st && tries < 3) begin
            cpu_step(mrp, mwp, adr, l, st);
            tries++;
        end
        if (tries > 0) chk("stalled_op_retried", {31'b0, st}, 32'd0);
    endtask

    // Full four-phase spy transaction; lat counts edges from request to ack.
    task automatic spy_txn(input logic wr, input logic [4:0] adr, input logic [31:0] data,
                           output int lat);
        int n;
        spy_wr = wr; spy_adr = adr; spy_wdata = data; spy_req = 1'b1;
        if (wr) begin
            exp_mem[adr] = data;
            spy_q.push_back({1'b1, data});
        end else begin
            spy_q.push_back({1'b0, exp_mem[adr]});
        end
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            // Spy fields are don't-care once latched.
            spy_wr = 1'($urandom); spy_adr = 5'($urandom); spy_wdata = $urandom;
        end while (!spy_ack && lat < 40);
        if (!spy_ack) chk("spy_ack_timeout", {31'b0, spy_ack}, 32'd1);
        spy_req = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (spy_ack && n < 5);
        chk("spy_ack_release", {31'b0, spy_ack}, 32'd0);
    endtask

    // Scoreboard monitor.
    always begin
        @(posedge clk);
        #2;
        if (cpu_q.size() > 0) chk("cpu_mmem", cpu_mmem, cpu_q.pop_front());
        if (spy_ack && !ack_prev) begin
            if (spy_q.size() == 0) begin
                chk("spy_unexpected_ack", {31'b0, spy_ack}, 32'd0);
            end else begin
                logic [32:0] e;
                e = spy_q.pop_front();
                if (!e[32]) chk("spy_rdata", spy_rdata, e[31:0]);
            end
        end
        ack_prev = spy_ack;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, g0_cnt, s0_cnt, n;
        logic st;
        for (int i = 0; i < 32; i++) exp_mem[i] = '0;
        last_rd = '0; cyc = 0; stall_cnt = 0; stall_at = -1; cpu_done = 1'b0;
        spy_req = 0; spy_wr = 0; spy_adr = '0; spy_wdata = '0;
        spy_req0 = 0; spy_wr0 = 0; spy_adr0 = 5'd2; spy_wdata0 = '0;

        // Reset with CPU driving both enables.
        reset = 1'b1; ram_clr = 1'b1;
        cpu_mrp = 1; cpu_mwp = 1; cpu_madr = 5'd3; cpu_l = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_mrp", {31'b0, mem_mrp}, 32'd0);
        chk("rst_mem_mwp", {31'b0, mem_mwp}, 32'd0);
        chk("rst_mem_mwp_nf", {31'b0, mem_mwp0}, 32'd0);
        chk("rst_cpu_mmem", cpu_mmem, 32'd0);
        chk("rst_cpu_stall", {31'b0, cpu_stall}, 32'd0);
        chk("rst_spy_ack", {31'b0, spy_ack}, 32'd0);
        chk("rst_spy_rdata", spy_rdata, 32'd0);
        cpu_mrp = 0; cpu_mwp = 0;
        @(posedge clk); #1;
        reset = 1'b0; ram_clr = 1'b0;

        // Idle CPU: spy write then read of adr 5.
        spy_txn(1'b1, 5'd5, 32'hDEAD_BEEF, lat);
        chk("spy_wr_latency", lat, 32'd3);
        spy_txn(1'b0, 5'd5, 32'd0, lat);
        chk("spy_rd_latency", lat, 32'd4);
        chk("spy_rdata_hold", spy_rdata, 32'hDEAD_BEEF);

        // Preload.
        cpu_op(0, 1, 5'd3, 32'h1234_5678);
        cpu_op(0, 1, 5'd9, 32'h0000_0001);
        cpu_op(0, 1, 5'd2, 32'hCAFE_0002);
        spy_txn(1'b1, 5'd7, 32'h0BAD_F00D, lat);

        // CPU read of adr 3, spy read of adr 7 granted in the next idle cycle.
        fork
            spy_txn(1'b0, 5'd7, 32'd0, lat);
            begin
                cpu_op(1, 0, 5'd3, 0);
                cpu_op(1, 0, 5'd3, 0);
                cpu_op(0, 0, 5'd0, 0);
                cpu_op(0, 0, 5'd0, 0);
            end
        join
        chk("shadow_spy_latency", lat, 32'd5);
        chk("shadow_cpu_mmem", cpu_mmem, 32'h1234_5678);
        chk("shadow_spy_rdata", spy_rdata, 32'h0BAD_F00D);

        // Busy CPU: one forced grant in the fifth wait cycle.
        cyc = 0; stall_cnt = 0; stall_at = -1;
        fork
            spy_txn(1'b0, 5'd7, 32'd0, lat);
            for (int i = 0; i < 12; i++) begin
                if (i % 2 == 0) cpu_op(0, 1, 5'(20 + i / 2), 32'h1000 + i);
                else cpu_op(1, 0, 5'(20 + i / 2), 0);
            end
        join
        chk("stall_count", stall_cnt, 32'd1);
        chk("stall_cycle", stall_at, 32'd5);
        chk("forced_latency", lat, Starve + 4);
        for (int i = 0; i < 6; i++) cpu_op(1, 0, 5'(20 + i), 0);
        cpu_op(0, 0, 5'd0, 0);

        // STARVE_LIMIT = 0 instance: no forcing under a long busy run.
        g0_cnt = 0; s0_cnt = 0;
        spy_req0 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cpu_op(1, 0, 5'(20 + i % 8), 0);
            g0_cnt += int'(g0);
            s0_cnt += int'(s0);
        end
        chk("nf_no_grant", g0_cnt, 32'd0);
        chk("nf_no_stall", s0_cnt, 32'd0);
        cpu_step(0, 0, 5'd0, 0, st);
        chk("nf_grant_on_idle", {31'b0, g0}, 32'd1);
        n = 0;
        while (!spy_ack0 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("nf_ack", {31'b0, spy_ack0}, 32'd1);
        chk("nf_rdata", spy_rdata0, 32'hCAFE_0002);
        spy_req0 = 1'b0;
        @(posedge clk); #1;
        chk("nf_ack_release", {31'b0, spy_ack0}, 32'd0);

        // Read-and-write in one CPU op on adr 9.
        cpu_op(1, 1, 5'd9, 32'hA5A5_A5A5);
`ifdef MMEM_ARB_BYPASS_EN
        chk("rw_same_op", cpu_mmem, 32'hA5A5_A5A5);
`else
        chk("rw_same_op", cpu_mmem, 32'h0000_0001);
`endif
        cpu_op(0, 0, 5'd0, 0);
        cpu_op(1, 0, 5'd9, 0);
        chk("rw_readback", cpu_mmem, 32'hA5A5_A5A5);
        cpu_op(0, 0, 5'd0, 0);
        @(posedge clk); #1;

        // Reset while the spy read sits in RDATA.
        spy_wr = 1'b0; spy_adr = 5'd7; spy_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        cpu_mrp = 1; cpu_mwp = 1; cpu_madr = 5'd4; cpu_l = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("rdata_rst_mem_mwp", {31'b0, mem_mwp}, 32'd0);
        chk("rdata_rst_mem_mrp", {31'b0, mem_mrp}, 32'd0);
        @(posedge clk); #1;
        chk("rdata_rst_ack", {31'b0, spy_ack}, 32'd0);
        chk("rdata_rst_rdata", spy_rdata, 32'd0);
        @(posedge clk); #1;
        chk("rdata_rst_ack2", {31'b0, spy_ack}, 32'd0);
        chk("rdata_rst_cpu_mmem", cpu_mmem, 32'd0);
        cpu_mrp = 0; cpu_mwp = 0;
        reset = 1'b0;
        last_rd = '0;
        spy_txn(1'b0, 5'd7, 32'd0, lat);
        chk("restart_latency", lat, 32'd4);
        cpu_op(1, 0, 5'd4, 0);
        cpu_op(0, 0, 5'd0, 0);

        // Randomized traffic: CPU on 16..31, spy on 0..15.
        fork
            begin
                for (int i = 0; i < 600; i++) begin
                    int unsigned r;
                    logic [4:0]  a;
                    r = $urandom_range(0, 9);
                    a = 5'(16 + $urandom_range(0, 15));
                    if (r < 2) cpu_op(0, 0, a, 0);
                    else if (r < 6) cpu_op(1, 0, a, 0);
                    else if (r < 9) cpu_op(0, 1, a, $urandom);
                    else cpu_op(1, 1, a, $urandom);
                end
                cpu_done = 1'b1;
            end
            begin
                int rl;
                while (!cpu_done) begin
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk); #1;
                    end
                    if (!cpu_done) begin
                        spy_txn(1'($urandom), 5'($urandom_range(0, 15)), $urandom, rl);
                        chk("spy_wait_bound", {31'b0, rl <= int'(Starve + 4)}, 32'd1);
                    end
                end
            end
        join
        cpu_op(0, 0, 5'd0, 0);
        for (int i = 16; i < 32; i++) cpu_op(1, 0, 5'(i), 0);
        cpu_op(0, 0, 5'd0, 0);
        for (int i = 0; i < 16; i++) spy_txn(1'b0, 5'(i), 32'd0, lat);

        repeat (3) @(posedge clk);
        #3;
        chk("cpu_queue_drained", cpu_q.size(), 32'd0);
        chk("spy_queue_drained", spy_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
